// File: rtl/bus_contention_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_contention_monitor_if
// Description : Bundle of the observed bus enables/gates, the clear strobe and
//               the monitor status outputs.
//               master : the side that supplies enables/gates/clear and reads
//                        status (bench, status-register wrapper).
//               slave  : the monitor itself.
//               Signals:
//                 oe_i          NUM_BUSES*NUM_DRIVERS  enables, bus b driver d
//                                                      at bit b*NUM_DRIVERS+d
//                 gate_ni       NUM_BUSES              active-low gate per bus
//                 clear_i       1                      clear sticky/count/first
//                 violation_o   1                      new-violation pulse
//                 active_o      NUM_BUSES              bus in declared violation
//                 sticky_o      NUM_BUSES              bus violated since clear
//                 count_o       CNT_WIDTH              saturating episode count
//                 first_valid_o 1                      first capture held
//                 first_bus_o   c_bus_w                first violating bus
//                 first_oe_o    NUM_DRIVERS            its oe slice
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_contention_monitor_if #(
    parameter int NUM_BUSES   = 3,
    parameter int NUM_DRIVERS = 2,
    parameter int CNT_WIDTH   = 16
);
    localparam int c_bus_w = (NUM_BUSES > 1) ? $clog2(NUM_BUSES) : 1;

    logic [NUM_BUSES*NUM_DRIVERS-1:0] oe_i;
    logic [NUM_BUSES-1:0]             gate_ni;
    logic                             clear_i;
    logic                             violation_o;
    logic [NUM_BUSES-1:0]             active_o;
    logic [NUM_BUSES-1:0]             sticky_o;
    logic [CNT_WIDTH-1:0]             count_o;
    logic                             first_valid_o;
    logic [c_bus_w-1:0]               first_bus_o;
    logic [NUM_DRIVERS-1:0]           first_oe_o;

    modport master (
        output oe_i, gate_ni, clear_i,
        input  violation_o, active_o, sticky_o, count_o,
               first_valid_o, first_bus_o, first_oe_o
    );

    modport slave (
        input  oe_i, gate_ni, clear_i,
        output violation_o, active_o, sticky_o, count_o,
               first_valid_o, first_bus_o, first_oe_o
    );
endinterface
`default_nettype wire

// File: rtl/bus_contention_monitor.sv
`default_nettype none
// ============================================================================
// Module      : bus_contention_monitor
// Description : Watches per-bus output-enable vectors from several potential
//               drivers and declares a violation when a conflict persists for
//               GRACE_CYCLES+1 consecutive cycles.
//               Exclusive bus : conflict when more than one driver is enabled.
//               Gated bus     : conflict when driver 0's enable differs from
//                               the (active-low) gate.
//               Episodes are counted (saturating), buses are flagged sticky,
//               and the first offender with its enable slice is latched.
// Ports       : clk_i     in  system clock, rising edge
//               reset_ni  in  synchronous active-low reset
//               mon       slave modport of bus_contention_monitor_if
//                         (oe_i, gate_ni, clear_i in; status outputs out)
// Revision    : 1.0 - initial release
// ============================================================================
module bus_contention_monitor #(
    parameter int                   NUM_BUSES    = 3,
    parameter int                   NUM_DRIVERS  = 2,
    parameter logic [NUM_BUSES-1:0] GATED_MASK   = '0,
    parameter int                   GRACE_CYCLES = 0,
    parameter int                   CNT_WIDTH    = 16
) (
    input  wire logic                  clk_i,
    input  wire logic                  reset_ni,
    bus_contention_monitor_if.slave    mon
);

    localparam int         c_bus_w   = (NUM_BUSES > 1) ? $clog2(NUM_BUSES) : 1;
    localparam int         c_sum_w   = $clog2(NUM_BUSES + 1);
    localparam logic [7:0] c_grace   = 8'(GRACE_CYCLES);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_pending = 2'd1;
    localparam logic [1:0] c_active  = 2'd2;

    logic [NUM_BUSES-1:0] w_declare;
    logic [NUM_BUSES-1:0] w_active;

    // ------------------------------------------------------------------------
    // Per-bus conflict detection and episode FSM
    // ------------------------------------------------------------------------
    for (genvar b = 0; b < NUM_BUSES; b++) begin : g_bus
        logic [NUM_DRIVERS-1:0] w_slice;
        logic                   w_raw;
        logic [1:0]             r_state;
        logic [1:0]             w_state_nxt;
        logic [7:0]             r_run;
        logic [7:0]             w_run_nxt;
        logic                   w_act_b;
        logic                   w_decl_b;

        assign w_slice = mon.oe_i[b*NUM_DRIVERS +: NUM_DRIVERS];

        if (GATED_MASK[b]) begin : g_gated
            // Driver 0 must be enabled exactly when the gate is asserted
            // (gate low), so equality of oe[0] and gate_n is the mismatch.
            assign w_raw = (w_slice[0] == mon.gate_ni[b]);
        end else begin : g_excl
            // x & (x-1) clears the lowest set bit; anything left means >=2 set.
            assign w_raw = |(w_slice & (w_slice - NUM_DRIVERS'(1)));
        end

        always_ff @(posedge clk_i) begin
            if (!reset_ni) begin
                r_state <= c_idle;
                r_run   <= 8'd0;
            end else begin
                r_state <= w_state_nxt;
                r_run   <= w_run_nxt;
            end
        end

        // r_run counts conflicting cycles already seen while PENDING; the
        // edge where it equals the grace budget with the conflict still
        // present is cycle GRACE_CYCLES+1, which declares.
        always_comb begin
            w_state_nxt = r_state;
            w_run_nxt   = r_run;
            case (r_state)
                c_idle: begin
                    if (w_raw) begin
                        if (GRACE_CYCLES == 0) begin
                            w_state_nxt = c_active;
                            w_run_nxt   = 8'd0;
                        end else begin
                            w_state_nxt = c_pending;
                            w_run_nxt   = 8'd1;
                        end
                    end
                end
                c_pending: begin
                    if (!w_raw) begin
                        w_state_nxt = c_idle;
                        w_run_nxt   = 8'd0;
                    end else if (r_run == c_grace) begin
                        w_state_nxt = c_active;
                        w_run_nxt   = 8'd0;
                    end else begin
                        w_run_nxt   = r_run + 8'd1;
                    end
                end
                c_active: begin
                    if (!w_raw) begin
                        w_state_nxt = c_idle;
                    end
                end
                default: begin
                    w_state_nxt = c_idle;
                    w_run_nxt   = 8'd0;
                end
            endcase
        end

        // Declaration is the single edge that enters ACTIVE; staying there
        // never re-declares.
        always_comb begin
            w_act_b  = (r_state == c_active);
            w_decl_b = (r_state != c_active) && (w_state_nxt == c_active);
        end

        assign w_active[b]  = w_act_b;
        assign w_declare[b] = w_decl_b;
    end

    // ------------------------------------------------------------------------
    // Episode count, first-offender selection
    // ------------------------------------------------------------------------
    logic [c_sum_w-1:0]           w_decl_cnt;
    logic [CNT_WIDTH+c_sum_w-1:0] w_sum;
    logic [CNT_WIDTH-1:0]         w_count_nxt;
    logic                         w_first_hit;
    logic [c_bus_w-1:0]           w_first_idx;
    logic [NUM_DRIVERS-1:0]       w_first_oe;

    logic                         r_violation;
    logic [NUM_BUSES-1:0]         r_sticky;
    logic [CNT_WIDTH-1:0]         r_count;
    logic                         r_first_valid;
    logic [c_bus_w-1:0]           r_first_bus;
    logic [NUM_DRIVERS-1:0]       r_first_oe;

    always_comb begin
        w_decl_cnt  = '0;
        w_first_hit = 1'b0;
        w_first_idx = '0;
        w_first_oe  = '0;
        // Scan high to low so the lowest-index declaring bus wins.
        for (int i = NUM_BUSES - 1; i >= 0; i--) begin
            if (w_declare[i]) begin
                w_first_hit = 1'b1;
                w_first_idx = c_bus_w'(i);
                w_first_oe  = mon.oe_i[i*NUM_DRIVERS +: NUM_DRIVERS];
            end
        end
        for (int i = 0; i < NUM_BUSES; i++) begin
            w_decl_cnt = w_decl_cnt + c_sum_w'(w_declare[i]);
        end
        // Extra headroom bits make overflow visible so the count can pin at
        // all-ones instead of wrapping.
        w_sum = {{c_sum_w{1'b0}}, r_count} + (CNT_WIDTH + c_sum_w)'(w_decl_cnt);
        if (|w_sum[CNT_WIDTH +: c_sum_w]) begin
            w_count_nxt = '1;
        end else begin
            w_count_nxt = w_sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_violation   <= 1'b0;
            r_sticky      <= '0;
            r_count       <= '0;
            r_first_valid <= 1'b0;
            r_first_bus   <= '0;
            r_first_oe    <= '0;
        end else begin
            r_violation <= |w_declare;
            // Clear wins over a same-edge declaration; that declaration is
            // dropped from the bookkeeping but the FSM still goes ACTIVE.
            if (mon.clear_i) begin
                r_sticky      <= '0;
                r_count       <= '0;
                r_first_valid <= 1'b0;
                r_first_bus   <= '0;
                r_first_oe    <= '0;
            end else begin
                r_sticky <= r_sticky | w_declare;
                r_count  <= w_count_nxt;
                if (!r_first_valid && w_first_hit) begin
                    r_first_valid <= 1'b1;
                    r_first_bus   <= w_first_idx;
                    r_first_oe    <= w_first_oe;
                end
            end
        end
    end

    assign mon.violation_o   = r_violation;
    assign mon.active_o      = w_active;
    assign mon.sticky_o      = r_sticky;
    assign mon.count_o       = r_count;
    assign mon.first_valid_o = r_first_valid;
    assign mon.first_bus_o   = r_first_bus;
    assign mon.first_oe_o    = r_first_oe;

endmodule
`default_nettype wire

// File: doc/bus_contention_monitor.md
Name: bus_contention_monitor

Overview:
- Parametrised, synthesizable successor to the simulation-only bus-drive assertions in the top-level driver.
- Watches per-bus output-enable vectors from N potential drivers (FPGA, CPU, MCU, ...) on one shared clock.
- Detects illegal overlap (exclusive mode) or enable/gate mismatch (gated mode, e.g. rx_oe vs /CS), with a programmable grace window.
- Counts violation episodes and latches the first offender; usable in the sim bench and on silicon via a status register.

Parameters:
- NUM_BUSES, 3, number of monitored buses.
- NUM_DRIVERS, 2, potential drivers per bus (>=2).
- GATED_MASK, 3'b000, bit b=1 puts bus b in gated mode, otherwise exclusive mode.
- GRACE_CYCLES, 0, consecutive conflicting cycles tolerated before a violation is declared (0..255).
- CNT_WIDTH, 16, width of the episode counter.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- reset_ni  in  1  synchronous active-low reset.
- oe_i  in  NUM_BUSES*NUM_DRIVERS  enables; bus b, driver d at bit b*NUM_DRIVERS+d.
- gate_ni  in  NUM_BUSES  active-low gate per bus; used only in gated mode.
- clear_i  in  1  synchronous clear of sticky/count/first-capture state.
- violation_o  out  1  one-cycle pulse when any bus newly declares a violation.
- active_o  out  NUM_BUSES  bus b currently in a declared violation.
- sticky_o  out  NUM_BUSES  bus b has declared a violation since reset/clear.
- count_o  out  CNT_WIDTH  saturating count of declared episodes.
- first_valid_o  out  1  first_bus_o/first_oe_o hold a captured violation.
- first_bus_o  out  $clog2(NUM_BUSES) (min 1)  index of the first violating bus.
- first_oe_o  out  NUM_DRIVERS  oe_i slice of that bus at declaration.

Behaviour:
- Reset (reset_ni=0 at an edge): all outputs 0, grace counters 0, episode state idle. Reset overrides clear_i and everything else.
- Raw conflict, exclusive bus: more than one bit of the bus's oe slice is set.
- Raw conflict, gated bus: oe[d=0] != ~gate_ni[b]. Driver 0 must be enabled iff the gate is asserted. Other drivers in the slice are ignored.
- Per-bus FSM states: IDLE, PENDING, ACTIVE.
  - IDLE: raw=1 and GRACE_CYCLES=0 -> ACTIVE. raw=1 and GRACE_CYCLES>0 -> PENDING with run=1.
  - PENDING: raw=0 -> IDLE, run=0. raw=1 -> run+1; when run reaches GRACE_CYCLES with raw still 1 -> ACTIVE.
  - ACTIVE: raw=0 -> IDLE.
- Declaration: the edge that enters ACTIVE. A violation must persist GRACE_CYCLES+1 consecutive sampled cycles. Input sampled at edge k gives active_o=1 after edge k+GRACE_CYCLES.
- On each declaration, in the same register update:
  - sticky_o[b] is set.
  - count_o adds the number of buses declaring this edge, saturating at all-ones (no wrap).
  - violation_o pulses high for one cycle.
- Staying in ACTIVE never re-counts. A new episode requires a return to IDLE first.
- First capture: if first_valid_o=0 at a declaring edge, capture the lowest-index declaring bus and its oe slice, and set first_valid_o. The capture is then frozen until reset/clear.
- clear_i=1: sticky_o, count_o, first_* are cleared, taking priority over declarations on the same edge.
  - FSMs and active_o are not affected.
  - An episode already ACTIVE is not re-counted after the clear.
  - A bus declaring on the clear edge still reaches ACTIVE and becomes active_o=1, but it is lost from sticky/count/first.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Exclusive, GRACE=0: bus0 oe=2'b11 for 1 cycle at edge 10 -> active_o[0]=1 and violation_o pulse after edge 10; count_o=1; first_bus_o=0; first_oe_o=2'b11; active_o[0]=0 after edge 11.
- Grace: GRACE_CYCLES=2, bus1 conflict for 2 cycles -> no violation, count_o=0. Conflict for 3 cycles -> exactly one pulse, after the 3rd edge.
- Gated: bus2 in GATED_MASK, gate_ni=0 with oe[0]=0 for 1 cycle -> violation on bus2; gate_ni=1 with oe[0]=0 -> no violation.
- Simultaneous: bus0 and bus2 declare on the same edge -> count_o+=2, one violation_o pulse, first_bus_o=0, sticky_o=3'b101.
- Saturation: CNT_WIDTH=2, 5 separate episodes -> count_o stays 2'b11.
- Clear and reset: a 10-cycle conflict with clear_i pulsed mid-episode -> count_o=0, active_o stays 1, no re-count. A second episode -> count_o=1. reset_ni=0 mid-episode -> all outputs 0 the next cycle.
